// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//
// Shares the single cache-bus port (cbus, toward the cbus-to-AXI converter)
// among NUM_REQ memory clients. The defaults are 0 = I-cache refill,
// 1 = D-cache refill/writeback and 2 = uncached. Arbitration is round-robin,
// and a grant is held for the whole burst. It is released only on the
// last-beat handshake from downstream.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   IDX_W    width of the grant index, derived from NUM_REQ; do not override
//
// Ports
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   ireq_*          per-requester request bundles, packed with requester i at
//                   slice i (valid, is_write, size[3], addr[32], strobe[4],
//                   data[32], len[4] = beats-1)
//   iresp_ready     per-requester beat handshake, only for the granted requester
//   iresp_last      per-requester final-beat flag, only for the granted requester
//   iresp_data      downstream read data, broadcast while a grant is active
//   oreq_*          request fields of the granted requester, toward downstream
//   oresp_ready     downstream beat handshake
//   oresp_last      downstream last-beat flag
//   oresp_data      downstream read data
//   busy            high while a grant is active
//   grant_idx       registered index of the current (or most recent) winner
// -----------------------------------------------------------------------------
module cbus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    ireq_valid,
  input  logic [NUM_REQ-1:0]    ireq_is_write,
  input  logic [NUM_REQ*3-1:0]  ireq_size,
  input  logic [NUM_REQ*32-1:0] ireq_addr,
  input  logic [NUM_REQ*4-1:0]  ireq_strobe,
  input  logic [NUM_REQ*32-1:0] ireq_data,
  input  logic [NUM_REQ*4-1:0]  ireq_len,
  output logic [NUM_REQ-1:0]    iresp_ready,
  output logic [NUM_REQ-1:0]    iresp_last,
  output logic [31:0]           iresp_data,
  output logic                  oreq_valid,
  output logic                  oreq_is_write,
  output logic [2:0]            oreq_size,
  output logic [31:0]           oreq_addr,
  output logic [3:0]            oreq_strobe,
  output logic [31:0]           oreq_data,
  output logic [3:0]            oreq_len,
  input  logic                  oresp_ready,
  input  logic                  oresp_last,
  input  logic [31:0]           oresp_data,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // ---------------------------------------------------------------------------
  // Unpack the per-requester buses so the output mux can index by requester.
  // ---------------------------------------------------------------------------
  logic [2:0]  req_size   [NUM_REQ];
  logic [31:0] req_addr   [NUM_REQ];
  logic [3:0]  req_strobe [NUM_REQ];
  logic [31:0] req_data   [NUM_REQ];
  logic [3:0]  req_len    [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_size[i]   = ireq_size[i*3 +: 3];
      req_addr[i]   = ireq_addr[i*32 +: 32];
      req_strobe[i] = ireq_strobe[i*4 +: 4];
      req_data[i]   = ireq_data[i*32 +: 32];
      req_len[i]    = ireq_len[i*4 +: 4];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin scan: the first valid requester at or above ptr, wrapping.
  // ptr_q + k is always below 2*NUM_REQ, so one conditional subtract performs
  // the modulo without a divider.
  // ---------------------------------------------------------------------------
  logic             scan_hit;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    scan_hit = 1'b0;
    scan_idx = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!scan_hit && ireq_valid[cand_idx]) begin
        scan_hit = 1'b1;
        scan_idx = cand_idx;
      end
    end
  end

  // A burst ends only on the downstream last-beat handshake.
  logic burst_done;
  assign burst_done = oresp_ready & oresp_last;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        // Downstream handshakes are meaningless here and are ignored.
        if (scan_hit) begin
          state_d = GRANT;
          sel_d   = scan_idx;
        end
      end
      GRANT: begin
        // No pre-emption: other requesters, and a dropped valid from the
        // winner, do not move the FSM.
        if (burst_done) begin
          state_d = IDLE;
          ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // Every output is zero in IDLE (and therefore during reset). The exception
  // is grant_idx, which always reflects the registered winner. sel_q only
  // ever holds codes below NUM_REQ, so the direct indexing stays in range.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = 1'b0;
    oreq_valid    = 1'b0;
    oreq_is_write = 1'b0;
    oreq_size     = '0;
    oreq_addr     = '0;
    oreq_strobe   = '0;
    oreq_data     = '0;
    oreq_len      = '0;
    iresp_ready   = '0;
    iresp_last    = '0;
    iresp_data    = '0;
    grant_idx     = sel_q;
    if (state_q == GRANT) begin
      busy               = 1'b1;
      oreq_valid         = ireq_valid[sel_q];
      oreq_is_write      = ireq_is_write[sel_q];
      oreq_size          = req_size[sel_q];
      oreq_addr          = req_addr[sel_q];
      oreq_strobe        = req_strobe[sel_q];
      oreq_data          = req_data[sel_q];
      oreq_len           = req_len[sel_q];
      iresp_ready[sel_q] = oresp_ready;
      iresp_last[sel_q]  = oresp_last;
      iresp_data         = oresp_data;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_arbiter
//
// Self-checking bench for cbus_arbiter. The main instance uses NUM_REQ=3 and a
// second instance uses NUM_REQ=2 for the wrap-around case. A transaction-level
// model tracks "who owns the bus, where the rotation starts, and how many
// beats have gone by". It predicts every output on every cycle. Directed
// scenarios add explicit expectations on grant order, beat counts and bubbles.
// -----------------------------------------------------------------------------
module tb_cbus_arbiter;

  localparam int N  = 3;
  localparam int NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (NUM_REQ = 3) ----------------
  logic            reset;
  logic [N-1:0]    ireq_valid, ireq_is_write;
  logic [N*3-1:0]  ireq_size;
  logic [N*32-1:0] ireq_addr, ireq_data;
  logic [N*4-1:0]  ireq_strobe, ireq_len;
  logic [N-1:0]    iresp_ready, iresp_last;
  logic [31:0]     iresp_data;
  logic            oreq_valid, oreq_is_write;
  logic [2:0]      oreq_size;
  logic [31:0]     oreq_addr, oreq_data;
  logic [3:0]      oreq_strobe, oreq_len;
  logic            oresp_ready, oresp_last;
  logic [31:0]     oresp_data;
  logic            busy;
  logic [1:0]      grant_idx;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
    .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
    .ireq_len(ireq_len),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
    .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
    .oreq_len(oreq_len),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
    .busy(busy), .grant_idx(grant_idx)
  );

  // ---------------- DUT B (NUM_REQ = 2) ----------------
  logic             reset_b;
  logic [NB-1:0]    b_ireq_valid, b_ireq_is_write;
  logic [NB*3-1:0]  b_ireq_size;
  logic [NB*32-1:0] b_ireq_addr, b_ireq_data;
  logic [NB*4-1:0]  b_ireq_strobe, b_ireq_len;
  logic [NB-1:0]    b_iresp_ready, b_iresp_last;
  logic [31:0]      b_iresp_data;
  logic             b_oreq_valid, b_oreq_is_write;
  logic [2:0]       b_oreq_size;
  logic [31:0]      b_oreq_addr, b_oreq_data;
  logic [3:0]       b_oreq_strobe, b_oreq_len;
  logic             b_oresp_ready, b_oresp_last;
  logic [31:0]      b_oresp_data;
  logic             b_busy;
  logic [0:0]       b_grant_idx;

  cbus_arbiter #(.NUM_REQ(NB)) dut_b (
    .clk(clk), .reset(reset_b),
    .ireq_valid(b_ireq_valid), .ireq_is_write(b_ireq_is_write), .ireq_size(b_ireq_size),
    .ireq_addr(b_ireq_addr), .ireq_strobe(b_ireq_strobe), .ireq_data(b_ireq_data),
    .ireq_len(b_ireq_len),
    .iresp_ready(b_iresp_ready), .iresp_last(b_iresp_last), .iresp_data(b_iresp_data),
    .oreq_valid(b_oreq_valid), .oreq_is_write(b_oreq_is_write), .oreq_size(b_oreq_size),
    .oreq_addr(b_oreq_addr), .oreq_strobe(b_oreq_strobe), .oreq_data(b_oreq_data),
    .oreq_len(b_oreq_len),
    .oresp_ready(b_oresp_ready), .oresp_last(b_oresp_last), .oresp_data(b_oresp_data),
    .busy(b_busy), .grant_idx(b_grant_idx)
  );

  // ---------------- Requester view (unpacked) ----------------
  logic        rq_valid  [N];
  logic        rq_write  [N];
  logic [2:0]  rq_size   [N];
  logic [31:0] rq_addr   [N];
  logic [3:0]  rq_strobe [N];
  logic [31:0] rq_data   [N];
  logic [3:0]  rq_len    [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ireq_valid[i]          = rq_valid[i];
      ireq_is_write[i]       = rq_write[i];
      ireq_size[i*3 +: 3]    = rq_size[i];
      ireq_addr[i*32 +: 32]  = rq_addr[i];
      ireq_strobe[i*4 +: 4]  = rq_strobe[i];
      ireq_data[i*32 +: 32]  = rq_data[i];
      ireq_len[i*4 +: 4]     = rq_len[i];
    end
  end

  // ---------------- Reference model state ----------------
  bit m_busy;    // a burst currently owns the bus
  int m_owner;   // owner of the current or most recent burst
  int m_ptr;     // first requester considered in the next rotation
  int m_beat;    // beats already accepted in the current burst

  int checks = 0;
  int errors = 0;

  // ---------------- DUT observations ----------------
  int   cnt_ready [N];
  int   cnt_last  [N];
  int   last_at   [N];
  int   obs_grants[$];
  bit   busy_hist [$];
  bit   prev_busy;
  logic obs_busy, obs_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int last_grant();
    if (obs_grants.size() == 0) return -1;
    return obs_grants[$];
  endfunction

  // Compare every DUT A output against the model, then log observations.
  task automatic check_outputs();
    bit         en;
    logic [N-1:0] exp_rdy, exp_last;
    en       = !reset && m_busy;
    exp_rdy  = '0;
    exp_last = '0;
    if (en && oresp_ready) exp_rdy[m_owner] = 1'b1;
    if (en && oresp_last)  exp_last[m_owner] = 1'b1;
    check("busy",          busy,          en);
    check("grant_idx",     grant_idx,     reset ? 0 : m_owner);
    check("oreq_valid",    oreq_valid,    en && rq_valid[m_owner]);
    check("oreq_is_write", oreq_is_write, en && rq_write[m_owner]);
    check("oreq_size",     oreq_size,     en ? rq_size[m_owner] : 3'd0);
    check("oreq_addr",     oreq_addr,     en ? rq_addr[m_owner] : 32'd0);
    check("oreq_strobe",   oreq_strobe,   en ? rq_strobe[m_owner] : 4'd0);
    check("oreq_data",     oreq_data,     en ? rq_data[m_owner] : 32'd0);
    check("oreq_len",      oreq_len,      en ? rq_len[m_owner] : 4'd0);
    check("iresp_ready",   iresp_ready,   exp_rdy);
    check("iresp_last",    iresp_last,    exp_last);
    check("iresp_data",    iresp_data,    en ? oresp_data : 32'd0);

    obs_busy  = busy;
    obs_valid = oreq_valid;
    for (int i = 0; i < N; i++) begin
      if (iresp_ready[i] === 1'b1) cnt_ready[i]++;
      if (iresp_last[i] === 1'b1) begin
        cnt_last[i]++;
        last_at[i] = cnt_ready[i];
      end
    end
    if (busy === 1'b1 && !prev_busy) obs_grants.push_back(int'(grant_idx));
    busy_hist.push_back(busy === 1'b1);
    prev_busy = (busy === 1'b1);
  endtask

  // Apply the arbitration rules at a clock edge.
  task automatic model_edge();
    bit found;
    int cand;
    if (reset) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beat = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && rq_valid[cand]) begin
          found = 1; m_busy = 1; m_owner = cand; m_beat = 0;
        end
      end
    end else if (oresp_ready) begin
      if (oresp_last) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        m_beat++;
      end
    end
  endtask

  // One clock cycle: drive the downstream response, check at the negedge,
  // and advance the model at the posedge.
  task automatic tick(input bit rdy, input bit force_last = 1'b0);
    oresp_ready = rdy;
    oresp_last  = force_last;
    if (rdy && m_busy && (m_beat == int'(rq_len[m_owner]))) oresp_last = 1'b1;
    oresp_data  = $urandom;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Run the open burst to completion. mode 0: always ready, 1: every other
  // cycle, 2: random.
  task automatic drain(input int mode, input int budget);
    int n;
    bit alt;
    n   = 0;
    alt = 0;
    while (m_busy && n < budget) begin
      case (mode)
        0:       tick(1'b1);
        1:       begin tick(alt); alt = !alt; end
        default: tick($urandom_range(0, 3) != 0);
      endcase
      n++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: burst open after %0d cycles, required closed", budget);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit wr, input logic [3:0] len);
    rq_valid[i]  = v;
    rq_write[i]  = wr;
    rq_size[i]   = 3'($urandom_range(0, 7));
    rq_addr[i]   = $urandom;
    rq_strobe[i] = 4'($urandom_range(0, 15));
    rq_data[i]   = $urandom;
    rq_len[i]    = len;
  endtask

  // Holds reset over two edges and leaves it asserted; the caller releases it.
  task automatic reset_dut();
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq_valid[i] = 1'b0;
    tick(1'b0);
    tick(1'b0);
  endtask

  int b0, b1, l0, l1, sr, sl, gsz;

  initial begin
    reset         = 1'b1;
    oresp_ready   = 1'b0;
    oresp_last    = 1'b0;
    oresp_data    = '0;
    prev_busy     = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beat = 0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 1'b0, 4'd0);
      cnt_ready[i] = 0; cnt_last[i] = 0; last_at[i] = 0;
    end
    reset_b         = 1'b1;
    b_ireq_valid    = '0;
    b_ireq_is_write = '0;
    b_ireq_size     = '0;
    b_ireq_addr     = '0;
    b_ireq_data     = '0;
    b_ireq_strobe   = '0;
    b_ireq_len      = '0;
    b_oresp_ready   = 1'b1;
    b_oresp_last    = 1'b1;
    b_oresp_data    = 32'h1234_5678;

    // ---- 1) single read burst len=3, downstream ready every other cycle ----
    reset_dut();
    set_req(0, 1'b1, 1'b0, 4'd3);
    reset = 1'b0;
    b0 = cnt_ready[0]; l0 = cnt_last[0];
    tick(1'b0);
    check("t1_idle_before_grant", obs_busy, 1'b0);
    tick(1'b0);
    check("t1_oreq_valid_latency", obs_valid, 1'b1);
    drain(1, 40);
    check("t1_ready_pulses", cnt_ready[0] - b0, 4);
    check("t1_last_pulses", cnt_last[0] - l0, 1);
    check("t1_last_on_4th", last_at[0] - b0, 4);
    set_req(1, 1'b1, 1'b0, 4'd0);     // req0 is still valid; ptr=1 must favour req1
    tick(1'b1);
    check("t1_bubble", obs_busy, 1'b0);
    tick(1'b1);
    check("t1_ptr1_winner", last_grant(), 1);
    drain(0, 20);

    // ---- 2) all requesters valid, single-beat bursts ----
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 4'd0);
    reset = 1'b0;
    busy_hist.delete();
    obs_grants.delete();
    for (int c = 0; c < 12; c++) tick(1'b1);
    check("t2_hist_len", busy_hist.size(), 12);
    for (int c = 0; c < 12 && c < busy_hist.size(); c++)
      check($sformatf("t2_busy_c%0d", c), busy_hist[c], c % 2);
    check("t2_grant_count", obs_grants.size(), 6);
    for (int k = 0; k < 6 && k < obs_grants.size(); k++)
      check($sformatf("t2_grant_%0d", k), obs_grants[k], k % 3);

    // ---- 3) req1 len=7 write; req0 arrives mid-burst ----
    reset_dut();
    set_req(1, 1'b1, 1'b1, 4'd7);
    reset = 1'b0;
    b0 = cnt_ready[0]; b1 = cnt_ready[1]; l1 = cnt_last[1];
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    set_req(0, 1'b1, 1'b0, 4'd0);
    drain(0, 40);
    check("t3_req1_beats", cnt_ready[1] - b1, 8);
    check("t3_req1_last", cnt_last[1] - l1, 1);
    check("t3_req0_no_ready", cnt_ready[0] - b0, 0);
    tick(1'b1);
    tick(1'b1);
    check("t3_req0_next", last_grant(), 0);
    drain(0, 20);

    // ---- 4) reset during beat 2; ptr must return to 0 ----
    reset_dut();
    set_req(1, 1'b1, 1'b0, 4'd0);
    reset = 1'b0;
    tick(1'b1);
    tick(1'b1);                        // req1 single beat, ptr moves to 2
    rq_valid[1] = 1'b0;
    set_req(2, 1'b1, 1'b0, 4'd3);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);                        // req2 beats 0 and 1 accepted
    check("t4_req2_granted", last_grant(), 2);
    reset = 1'b1;
    tick(1'b1);
    check("t4_busy_in_reset", obs_busy, 1'b0);
    check("t4_valid_in_reset", obs_valid, 1'b0);
    set_req(0, 1'b1, 1'b0, 4'd0);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b1);
    tick(1'b1);
    check("t4_req0_wins_tie", last_grant(), 0);
    drain(0, 20);

    // ---- 5) downstream handshake while IDLE with no requests ----
    reset_dut();
    reset = 1'b0;
    sr = 0; sl = 0;
    for (int i = 0; i < N; i++) begin sr -= cnt_ready[i]; sl -= cnt_last[i]; end
    gsz = obs_grants.size();
    repeat (4) tick(1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin sr += cnt_ready[i]; sl += cnt_last[i]; end
    check("t5_no_ready", sr, 0);
    check("t5_no_last", sl, 0);
    check("t5_idle", obs_busy, 1'b0);
    check("t5_no_grant", obs_grants.size() - gsz, 0);

    // ---- random traffic against the model ----
    reset_dut();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(m_busy && m_owner == i) && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 7)));
      end
      reset = ($urandom_range(0, 299) == 0);
      tick($urandom_range(0, 3) != 0);
    end
    reset = 1'b1;

    // ---- 6) NUM_REQ=2: req1 only, then both, pointer wrap ----
    b_ireq_valid = 2'b10;
    reset_b      = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t6a_busy_c%0d", c), b_busy, c % 2);
      if (c % 2 == 1) begin
        check($sformatf("t6a_idx_c%0d", c), b_grant_idx, 1);
        check($sformatf("t6a_ready_c%0d", c), b_iresp_ready, 2'b10);
      end
      @(posedge clk);
      #1;
    end
    b_ireq_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t6b_busy_c%0d", c), b_busy, c % 2);
      if (c % 2 == 1) begin
        check($sformatf("t6b_idx_c%0d", c), b_grant_idx, ((c - 1) / 2) % 2);
        check($sformatf("t6b_ready_c%0d", c), b_iresp_ready,
              (((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
